// File: rtl/paint_scanner.sv
// paint_scanner: raster coordinate generator for layered painters; resolves per-pixel
// layer priority and writes pixels through a skid FIFO. Optional macro PAINT_SCANNER_HITCNT_EN adds hit_count.
module paint_scanner #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          LATENCY    = 3,
  parameter int          NUM_LAYERS = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BG_COLOR   = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         new_frame,
  output logic signed [15:0]           paint_x,
  output logic signed [15:0]           paint_y,
  input  logic [NUM_LAYERS-1:0]        layer_enable,
  input  logic [NUM_LAYERS*16-1:0]     layer_color,
  output logic                         fb_wr_valid,
  input  logic                         fb_wr_ready,
  output logic [18:0]                  fb_wr_addr,
  output logic [15:0]                  fb_wr_data,
  output logic                         busy,
  output logic                         frame_done
`ifdef PAINT_SCANNER_HITCNT_EN
  ,
  output logic [18:0]                  hit_count
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FSTART = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]  state;
  logic [15:0] x_cnt;
  logic [15:0] y_cnt;
  logic [18:0] addr_cnt;

  logic        pipe_vld  [LATENCY];
  logic [18:0] pipe_addr [LATENCY];
  logic [31:0] inflight;

  logic [34:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic        issue;
  logic        last_xy;
  logic        drained;
  logic        push;
  logic        pop;
  logic [15:0] res_color;

  always_comb begin
    inflight = 32'd0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + 32'(pipe_vld[i]);
    end
  end

  // Coordinates in flight already own a FIFO slot, so the sum can never exceed the depth.
  assign issue   = (state == S_SCAN) && ((32'(fifo_count) + inflight) < 32'(FIFO_DEPTH));
  assign last_xy = (x_cnt == 16'(H_RES - 1)) && (y_cnt == 16'(V_RES - 1));
  assign drained = (inflight == 32'd0) && (fifo_count == '0);

  assign new_frame  = (state == S_FSTART);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DRAIN) && drained;
  assign paint_x    = issue ? $signed(x_cnt) : -16'sd1;
  assign paint_y    = issue ? $signed(y_cnt) : -16'sd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      x_cnt    <= '0;
      y_cnt    <= '0;
      addr_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_FSTART;
        S_FSTART: begin
          state    <= S_SCAN;
          x_cnt    <= '0;
          y_cnt    <= '0;
          addr_cnt <= '0;
        end
        S_SCAN: if (issue) begin
          addr_cnt <= addr_cnt + 19'd1;
          if (last_xy) begin
            state <= S_DRAIN;
          end else if (x_cnt == 16'(H_RES - 1)) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 16'd1;
          end else begin
            x_cnt <= x_cnt + 16'd1;
          end
        end
        S_DRAIN: if (drained) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage LATENCY-1 lines up with the layer answers for its coordinate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= issue;
      pipe_addr[0] <= addr_cnt;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  // Lowest-index enabled layer wins; the loop runs high to low so it overwrites last.
  always_comb begin
    res_color = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_enable[i]) res_color = layer_color[16*i +: 16];
    end
  end

  // Write port: fb_wr_valid/addr/data form one transfer that completes on a cycle with
  // fb_wr_valid && fb_wr_ready; until then the head entry stays put.
  assign push        = pipe_vld[LATENCY-1];
  assign pop         = fb_wr_valid && fb_wr_ready;
  assign fb_wr_valid = (fifo_count != '0);
  assign {fb_wr_addr, fb_wr_data} = fb_wr_valid ? fifo_mem[rd_ptr] : 35'd0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {pipe_addr[LATENCY-1], res_color};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef PAINT_SCANNER_HITCNT_EN
  logic [18:0] hit_acc;
  logic [18:0] hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_acc <= '0;
      hit_q   <= '0;
    end else begin
      if (state == S_FSTART)          hit_acc <= '0;
      else if (push && |layer_enable) hit_acc <= hit_acc + 19'd1;
      if (frame_done) hit_q <= hit_acc;
    end
  end

  // The frame total is presented during the frame_done cycle and held afterwards.
  assign hit_count = frame_done ? hit_acc : hit_q;
`endif

endmodule
